// File: rtl/fir_coef_bank_ctrl.sv
// fir_coef_bank_ctrl
// Double-buffered coefficient manager for the FIR datapath. The host writes
// taps into the shadow bank, then pulses commit; the banks swap on the next
// accepted sample, and settled_o reports when the FIR output has been computed
// only from the new taps.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data  shadow tap write (index 0..N)
//   commit            request a bank swap (1-cycle pulse)
//   sample_en         FIR input strobe (same as FIR data_i_en)
//   coef_o            active bank, tap k at [k*CW +: CW], CW = width_H+width_W
//   bank_o            active bank index
//   busy_o            commit pending or flushing
//   settled_o         FIR output depends only on the active bank
//   err_o             1-cycle pulse on a rejected write and/or commit
//
// Optional macro FIR_COEF_SYM_MIRROR_EN: an accepted write to tap k also
// writes tap N-k (symmetric linear-phase load).
module fir_coef_bank_ctrl #(
  parameter int width_H   = 5,
  parameter int width_W   = 20,
  parameter int N         = 32,
  parameter int log_N     = 5,
  parameter int FLUSH_LEN = N + log_N + 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic [log_N:0]                         wr_addr,
  input  logic [width_H+width_W-1:0]             wr_data,
  input  logic                                   commit,
  input  logic                                   sample_en,
  output logic [(N+1)*(width_H+width_W)-1:0]     coef_o,
  output logic                                   bank_o,
  output logic                                   busy_o,
  output logic                                   settled_o,
  output logic                                   err_o
);

  localparam int CW   = width_H + width_W;
  localparam int AW   = log_N + 1;
  localparam int CNTW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  localparam logic [CW-1:0]   ONE      = CW'(1) << width_W;
  localparam logic [AW-1:0]   N_A      = AW'(N);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

  state_t                  state;
  logic [CNTW-1:0]         flush_cnt;
  logic [CW-1:0]           mem [2][N+1];
  logic [(N+1)*CW-1:0]     shadow_flat;
  logic                    wr_ok;
  logic                    wr_rej;
  logic                    cmt_rej;

  // Shadow bank flattened so it can be loaded into coef_o in one edge.
  always_comb begin
    shadow_flat = '0;
    for (int unsigned k = 0; k <= N; k++)
      shadow_flat[k*CW +: CW] = mem[~bank_o][k];
  end

  always_comb begin
    wr_ok   = wr_en && (state != PEND) && (wr_addr <= N_A);
    wr_rej  = wr_en && !wr_ok;
    cmt_rej = commit && (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= N; k++) begin
        mem[0][k]           <= (k == 0) ? ONE : '0;
        mem[1][k]           <= (k == 0) ? ONE : '0;
        coef_o[k*CW +: CW]  <= (k == 0) ? ONE : '0;
      end
      state     <= IDLE;
      flush_cnt <= '0;
      bank_o    <= 1'b0;
      busy_o    <= 1'b0;
      settled_o <= 1'b1;
      err_o     <= 1'b0;
    end else begin
      err_o <= wr_rej || cmt_rej;

      if (wr_ok) begin
        mem[~bank_o][wr_addr] <= wr_data;
`ifdef FIR_COEF_SYM_MIRROR_EN
        mem[~bank_o][N_A - wr_addr] <= wr_data;
`endif
      end

      case (state)
        IDLE: begin
          if (commit) begin
            state  <= PEND;
            busy_o <= 1'b1;
          end
        end
        PEND: begin
          // Writes are blocked here, so the shadow is stable when copied.
          if (sample_en) begin
            bank_o    <= ~bank_o;
            coef_o    <= shadow_flat;
            flush_cnt <= '0;
            settled_o <= 1'b0;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          if (sample_en) begin
            if (flush_cnt == CNT_LAST) begin
              settled_o <= 1'b1;
              busy_o    <= 1'b0;
              state     <= IDLE;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
module tb_fir_coef_bank_ctrl;

  localparam int width_H = 5;
  localparam int width_W = 20;
  localparam int N       = 32;
  localparam int log_N   = 5;
  localparam int CW      = width_H + width_W;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  wr_en;
  logic [log_N:0]        wr_addr;
  logic [CW-1:0]         wr_data;
  logic                  commit;
  logic                  sample_en;
  logic [(N+1)*CW-1:0]   coef_o;
  logic                  bank_o;
  logic                  busy_o;
  logic                  settled_o;
  logic                  err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_coef_bank_ctrl #(
    .width_H(width_H), .width_W(width_W), .N(N), .log_N(log_N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .sample_en(sample_en),
    .coef_o(coef_o), .bank_o(bank_o), .busy_o(busy_o),
    .settled_o(settled_o), .err_o(err_o)
  );

  function automatic logic [63:0] tap(input int k);
    return 64'(coef_o[k*CW +: CW]);
  endfunction

  // Expected tap k after loading 1082+k into taps 0..32 in ascending order.
  function automatic logic [63:0] load_val(input int k);
`ifdef FIR_COEF_SYM_MIRROR_EN
    return 64'((k < N/2) ? 1082 + (N - k) : 1082 + k);
`else
    return 64'(1082 + k);
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    commit = 1'b0; sample_en = 1'b0;
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Reset state
    check("rst_tap0", tap(0), 64'h100000);
    for (int k = 1; k <= N; k++) check($sformatf("rst_tap%0d", k), tap(k), 64'd0);
    check("rst_bank", 64'(bank_o), 64'd0);
    check("rst_settled", 64'(settled_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);

    // Load shadow with 1082+k, then commit
    for (int k = 0; k <= N; k++) begin
      wr_en = 1'b1; wr_addr = 6'(k); wr_data = 25'(1082 + k);
      step();
    end
    wr_en = 1'b0;
    check("load_no_err", 64'(err_o), 64'd0);
    check("load_active_tap5", tap(5), 64'd0);
    commit = 1'b1; step(); commit = 1'b0;
    check("pend_busy", 64'(busy_o), 64'd1);
    for (int i = 0; i < 20; i++) step();
    check("pend_bank", 64'(bank_o), 64'd0);
    check("pend_busy20", 64'(busy_o), 64'd1);
    check("pend_tap0", tap(0), 64'h100000);

    // Swap on the first sample
    sample_en = 1'b1; step();
    check("swap_bank", 64'(bank_o), 64'd1);
    check("swap_tap5", tap(5), load_val(5));
    check("swap_tap0", tap(0), load_val(0));
    check("swap_tap32", tap(32), load_val(32));
    check("swap_settled", 64'(settled_o), 64'd0);

    // Flush: 38 samples unsettled, 39th settles
    for (int i = 0; i < 38; i++) step();
    check("flush38_settled", 64'(settled_o), 64'd0);
    check("flush38_busy", 64'(busy_o), 64'd1);
    step();
    sample_en = 1'b0;
    check("flush39_settled", 64'(settled_o), 64'd1);
    check("flush39_busy", 64'(busy_o), 64'd0);
    step();
    check("idle_bank", 64'(bank_o), 64'd1);

    // Out-of-range write in IDLE
    wr_en = 1'b1; wr_addr = 6'd33; wr_data = 25'd777; step(); wr_en = 1'b0;
    check("oor_err", 64'(err_o), 64'd1);
    check("oor_busy", 64'(busy_o), 64'd0);
    step();
    check("oor_err_clr", 64'(err_o), 64'd0);

    // Write during PEND is dropped
    commit = 1'b1; step(); commit = 1'b0;
    check("pend2_err", 64'(err_o), 64'd0);
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 25'd999; step(); wr_en = 1'b0;
    check("pendwr_err", 64'(err_o), 64'd1);
    check("pendwr_bank", 64'(bank_o), 64'd1);
    step();
    check("pendwr_err_clr", 64'(err_o), 64'd0);
    sample_en = 1'b1; step(); sample_en = 1'b0;
    check("swap2_bank", 64'(bank_o), 64'd0);
    check("swap2_tap0", tap(0), 64'h100000);
    check("swap2_tap3", tap(3), 64'd0);

    // Commit during FLUSH, then commit plus bad write in one cycle
    commit = 1'b1; step(); commit = 1'b0;
    check("flushcmt_err", 64'(err_o), 64'd1);
    check("flushcmt_bank", 64'(bank_o), 64'd0);
    check("flushcmt_busy", 64'(busy_o), 64'd1);
    commit = 1'b1; wr_en = 1'b1; wr_addr = 6'd40; step();
    commit = 1'b0; wr_en = 1'b0;
    check("dual_err", 64'(err_o), 64'd1);
    step();
    check("dual_err_clr", 64'(err_o), 64'd0);

    // Finish this flush
    sample_en = 1'b1;
    for (int i = 0; i < 39; i++) step();
    sample_en = 1'b0;
    check("flush2_settled", 64'(settled_o), 64'd1);
    check("flush2_busy", 64'(busy_o), 64'd0);

    // Single write to tap 3 (mirror check on tap 29), commit, swap
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 25'd2302; step(); wr_en = 1'b0;
    commit = 1'b1; step(); commit = 1'b0;
    sample_en = 1'b1; step();
    check("sym_bank", 64'(bank_o), 64'd1);
    check("sym_tap3", tap(3), 64'd2302);
`ifdef FIR_COEF_SYM_MIRROR_EN
    check("sym_tap29", tap(29), 64'd2302);
`else
    check("sym_tap29", tap(29), 64'd1111);
`endif
    check("sym_tap4", tap(4), load_val(4));

    // Reset at flush count 10
    for (int i = 0; i < 10; i++) step();
    sample_en = 1'b0;
    check("cnt10_settled", 64'(settled_o), 64'd0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("midrst_bank", 64'(bank_o), 64'd0);
    check("midrst_tap0", tap(0), 64'h100000);
    check("midrst_tap3", tap(3), 64'd0);
    check("midrst_settled", 64'(settled_o), 64'd1);
    check("midrst_busy", 64'(busy_o), 64'd0);
    commit = 1'b1; step(); commit = 1'b0;
    check("midrst_idle_cmt_err", 64'(err_o), 64'd0);
    check("midrst_idle_cmt_busy", 64'(busy_o), 64'd1);
    sample_en = 1'b1; step(); sample_en = 1'b0;
    check("midrst_shadow_tap3", tap(3), 64'd0);
    check("midrst_shadow_tap0", tap(0), 64'h100000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coef_bank_ctrl.md
Name: fir_coef_bank_ctrl

Overview:
- Double-buffered coefficient manager for the FIR filter datapath.
- A host writes taps into the shadow bank one at a time, then issues a commit.
- The block swaps banks coherently on a sample boundary, drives the flattened coefficient bus into the FIR, and reports when the filter output has fully settled on the new taps.
- Sits between the control/register interface and the FIR coefficient inputs.

Parameters:
- width_H, 5, integer bits of fixed-point coefficient
- width_W, 20, fractional bits of fixed-point coefficient
- N, 32, highest tap index (N+1 taps)
- log_N, 5, log2(N); wr_addr is log_N+1 bits wide
- FLUSH_LEN, N+log_N+2, accepted samples after a swap before output is settled

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  tap write strobe
- wr_addr  in  log_N+1  tap index 0..N
- wr_data  in  width_H+width_W  signed coefficient
- commit  in  1  request bank swap (1-cycle pulse)
- sample_en  in  1  same strobe as FIR data_i_en
- coef_o  out  (N+1)*(width_H+width_W)  active bank, tap k at bits [k*CW +: CW] (CW = width_H+width_W)
- bank_o  out  1  index of active bank
- busy_o  out  1  commit pending or flushing
- settled_o  out  1  FIR output computed purely from current bank
- err_o  out  1  1-cycle pulse on a rejected write or commit

Behaviour:
- Reset (rst_n=0 at posedge):
  - Both banks: tap 0 = 1<<width_W (1.0), all other taps 0.
  - bank_o=0, busy_o=0, settled_o=1, err_o=0, state IDLE, flush counter 0.
  - Reset mid-PEND/FLUSH aborts the operation; the shadow contents are lost.
- Storage:
  - Two banks of N+1 registers; shadow bank = !bank_o.
  - coef_o is registered and always reflects the active bank; it never shows a partially written set.
- Writes:
  - Accepted in IDLE and FLUSH when wr_addr<=N; they update the shadow tap on that edge.
  - After a swap, the shadow holds the previous active set; the host rewrites every tap it needs changed.
  - Writes in PEND, or with wr_addr>N, are dropped and err_o pulses the next cycle.
- State machine:
  - IDLE:
    - commit=1 -> PEND, busy_o=1.
    - commit with a simultaneous wr_en: the write is applied first, then the state goes to PEND.
  - PEND:
    - Waits for sample_en=1.
    - On that edge: bank_o toggles, coef_o loads the new bank, flush counter=0, settled_o=0, go to FLUSH.
    - Commit in PEND: ignored, err_o pulse.
  - FLUSH:
    - Each sample_en=1 increments the counter.
    - On the edge where the counter reaches FLUSH_LEN-1 with sample_en=1: settled_o=1, busy_o=0, go to IDLE.
    - Commit in FLUSH: ignored, err_o pulse.
- Latency:
  - coef_o changes exactly one clock after the sample_en edge that performs the swap.
  - settled_o rises after FLUSH_LEN accepted samples.
  - No progress while sample_en=0; no timeout.
- err_o asserts for one cycle per rejected event; if two events occur in the same cycle, it still asserts for only one cycle.

Optional Feature:
- Macro: FIR_COEF_SYM_MIRROR_EN.
- Defined:
  - An accepted write to address k also writes address N-k with the same data (linear-phase symmetric load; k=N/2 written once).
  - Write acceptance and err_o rules are unchanged and based on k.
- Undefined: only address k is written; no mirror logic is synthesized.

Test Plan:
- Reset then idle 10 cycles:
  - coef_o tap0 = 0x100000, taps1..32 = 0.
  - bank_o=0, settled_o=1, busy_o=0.
- Write taps 0..32 = 1082+k, commit, hold sample_en=0 for 20 cycles:
  - bank_o stays 0, busy_o=1.
  - First sample_en pulse -> next cycle bank_o=1 and coef_o tap5 = 1087.
- After the swap, apply 38 sample_en pulses:
  - settled_o stays 0.
  - 39th pulse -> settled_o=1, busy_o=0 on the following cycle.
- wr_addr=33 in IDLE; wr_en during PEND; commit during FLUSH:
  - Each produces a 1-cycle err_o.
  - Shadow contents, state and bank_o are unchanged.
- Assert rst_n=0 during FLUSH at count 10:
  - Next cycle: bank_o=0, coef_o = unity, settled_o=1, state IDLE.
- With FIR_COEF_SYM_MIRROR_EN: write addr 3 = 2302, commit, swap:
  - coef_o tap3 = tap29 = 2302.
  - Without the macro, tap29 retains its prior value.
